// File: rtl/cb_scalar_search.sv
// cb_scalar_search: sweeps a K-entry scalar codebook, one entry per clock, and
// returns index, value and error of the entry nearest a signed Q15.16 target.
// Optional macro CBS_SQERR_EN: squared error metric instead of absolute error.
module cb_scalar_search #(
    parameter int unsigned N  = 32,
    parameter int unsigned K  = 16,
    parameter int unsigned AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N-1:0]      target,
    output logic [AW-1:0]     rom_addr,
    input  logic [N-1:0]      rom_data,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     best_index,
    output logic [N-1:0]      best_value,
    output logic [2*N+1:0]    best_err
);

    localparam int unsigned DW    = N + 1;
    localparam int unsigned ERR_W = 2 * N + 2;
    localparam logic [AW-1:0] LAST = AW'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [N-1:0]        tgt_q, tgt_d;
    logic [AW-1:0]       bidx_q, bidx_d;
    logic [N-1:0]        bval_q, bval_d;
    logic [ERR_W-1:0]    berr_q, berr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DW-1:0]       diff;
    logic [DW-1:0]       mag;
    logic [ERR_W-1:0]    err;
    logic                better;

    // Error of the current ROM entry against the latched target
    always_comb begin
        diff = {tgt_q[N-1], tgt_q} - {rom_data[N-1], rom_data};
        mag  = diff[DW-1] ? (~diff + DW'(1)) : diff;
`ifdef CBS_SQERR_EN
        err  = ERR_W'(mag) * ERR_W'(mag);
`else
        err  = ERR_W'(mag);
`endif
        better = (err < berr_q);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SCAN;
            S_SCAN:  if (cnt_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; strict compare keeps the lowest index on ties
    always_comb begin
        cnt_d  = cnt_q;
        tgt_d  = tgt_q;
        bidx_d = bidx_q;
        bval_d = bval_q;
        berr_d = berr_q;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d  = '0;
                    tgt_d  = target;
                    berr_d = '1;
                end
            end
            S_SCAN: begin
                if (better) begin
                    bidx_d = cnt_q;
                    bval_d = rom_data;
                    berr_d = err;
                end
                cnt_d = (cnt_q == LAST) ? '0 : cnt_q + AW'(1);
            end
            S_DONE: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tgt_q  <= '0;
            bidx_q <= '0;
            bval_q <= '0;
            berr_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tgt_q  <= tgt_d;
            bidx_q <= bidx_d;
            bval_q <= bval_d;
            berr_q <= berr_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign rom_addr   = cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign best_index = bidx_q;
    assign best_value = bval_q;
    assign best_err   = berr_q;

endmodule
